// File: rtl/sum_display_driver.sv
// Converts a 5-bit adder sum to two BCD digits with a shift-and-add-3 sequencer
// and drives a two-digit multiplexed, active-low seven-segment display.
module sum_display_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic [4:0] in_sum,
    input  logic       in_load,
    output logic [6:0] out_seg,
    output logic [1:0] out_an,
    output logic       out_busy,
    output logic       out_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;

    state_e      state_q;
    logic [4:0]  shift_q;
    logic [3:0]  tens_q;
    logic [3:0]  ones_q;
    logic [2:0]  iter_q;
    logic        busy_q;
    logic        done_q;

    logic [3:0]  tensAdj;
    logic [3:0]  onesAdj;
    logic [12:0] dabble;

    // One double-dabble step: correct each BCD nibble, then shift the whole chain.
    always_comb begin
        onesAdj = (ones_q >= 4'd5) ? ones_q + 4'd3 : ones_q;
        tensAdj = (tens_q >= 4'd5) ? tens_q + 4'd3 : tens_q;
        dabble  = {tensAdj, onesAdj, shift_q} << 1;
    end

    // busy_q stays high through the done cycle, so a load there is also ignored.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (in_load && !busy_q) begin
                        shift_q <= in_sum;
                        tens_q  <= '0;
                        ones_q  <= '0;
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    {tens_q, ones_q, shift_q} <= dabble;
                    iter_q <= iter_q + 3'd1;
                    if (iter_q == 3'd4) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    logic [3:0]       dispTens_q, dispTens_d;
    logic [3:0]       dispOnes_q, dispOnes_d;
    logic [CNT_W-1:0] refreshCnt_q, refreshCnt_d;
    logic             selTens_q, selTens_d;
    logic [3:0]       digit;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;

    // Segments are computed from next-cycle digit values so a commit is visible immediately.
    always_comb begin
        dispTens_d = dispTens_q;
        dispOnes_d = dispOnes_q;
        if (state_q == COMMIT) begin
            dispTens_d = tens_q;
            dispOnes_d = ones_q;
        end

        if (refreshCnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            refreshCnt_d = '0;
            selTens_d    = ~selTens_q;
        end else begin
            refreshCnt_d = refreshCnt_q + CNT_W'(1);
            selTens_d    = selTens_q;
        end

        digit = selTens_d ? dispTens_d : dispOnes_d;
        case (digit)
            4'd0:    seg_d = 7'b1000000;
            4'd1:    seg_d = 7'b1111001;
            4'd2:    seg_d = 7'b0100100;
            4'd3:    seg_d = 7'b0110000;
            4'd4:    seg_d = 7'b0011001;
            4'd5:    seg_d = 7'b0010010;
            4'd6:    seg_d = 7'b0000010;
            4'd7:    seg_d = 7'b1111000;
            4'd8:    seg_d = 7'b0000000;
            4'd9:    seg_d = 7'b0010000;
            default: seg_d = 7'b0111111;
        endcase
        if (BLANK_LZ && selTens_d && (dispTens_d == 4'd0)) begin
            seg_d = 7'b1111111;
        end

        an_d = selTens_d ? 2'b01 : 2'b10;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            dispTens_q   <= '0;
            dispOnes_q   <= '0;
            refreshCnt_q <= '0;
            selTens_q    <= 1'b0;
            seg_q        <= 7'b1000000;
            an_q         <= 2'b10;
        end else begin
            dispTens_q   <= dispTens_d;
            dispOnes_q   <= dispOnes_d;
            refreshCnt_q <= refreshCnt_d;
            selTens_q    <= selTens_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign out_seg  = seg_q;
    assign out_an   = an_q;
    assign out_busy = busy_q;
    assign out_done = done_q;

endmodule

// File: tb/tb_sum_display_driver.sv
// Self-checking bench for sum_display_driver: expected digits are queued at each
// accepted load and compared against the multiplexed display after out_done.
module tb_sum_display_driver;

    localparam int DIV = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       load  = 1'b0;
    logic [4:0] sum   = '0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       busy;
    logic       done;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] sbQ[$];

    always #5 clk = ~clk;

    sum_display_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .in_sum   (sum),
        .in_load  (load),
        .out_seg  (seg),
        .out_an   (an),
        .out_busy (busy),
        .out_done (done)
    );

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [6:0] segCode(input int d, input bit isTens);
        if (isTens && d == 0) return 7'b1111111;
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Pulses in_load for edge k and scrambles in_sum afterwards; returns at the negedge after edge k.
    task automatic applyStimulus(input int v);
        sum  = 5'(v);
        load = 1'b1;
        sbQ.push_back({4'(v / 10), 4'(v % 10)});
        @(negedge clk);
        load = 1'b0;
        sum  = 5'($urandom_range(0, 31));
    endtask

    // Index i is the cycle following edge k+i; optional extra load at index loadIdx.
    task automatic waitConversion(input int loadIdx, input int loadVal,
                                  output int busyCnt, output int doneCnt, output int doneIdx,
                                  output logic [6:0] doneSeg, output logic [1:0] doneAn);
        busyCnt = 0;
        doneCnt = 0;
        doneIdx = -1;
        doneSeg = 'x;
        doneAn  = 'x;
        for (int i = 0; i < 20; i++) begin
            if (busy) busyCnt++;
            if (done) begin
                doneCnt++;
                doneIdx = i;
                doneSeg = seg;
                doneAn  = an;
            end
            if (!busy) break;
            if (i == loadIdx) begin
                load = 1'b1;
                sum  = 5'(loadVal);
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic captureDisplay(output logic [6:0] onesSeg, output logic [6:0] tensSeg,
                                  output int badAn, output int doneSeen);
        onesSeg  = 'x;
        tensSeg  = 'x;
        badAn    = 0;
        doneSeen = 0;
        for (int i = 0; i < 2 * DIV + 1; i++) begin
            @(negedge clk);
            if (an == 2'b10) onesSeg = seg;
            else if (an == 2'b01) tensSeg = seg;
            else badAn++;
            if (done) doneSeen++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        testsRun++;
        if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
        testsRun++;
        if (an !== 2'b10) begin testsFailed++; $display("[TB] FAIL reset_an: got %b, expected 10", an); end
        testsRun++;
        if (seg !== 7'b1000000) begin testsFailed++; $display("[TB] FAIL reset_seg: got %b, expected 1000000", seg); end
        rst_n = 1'b1;
    endtask

    task automatic test_refresh();
        logic [1:0] expAn;
        logic [6:0] expSeg;
        for (int i = 0; i < 12; i++) begin
            expAn  = (((i / DIV) % 2) == 0) ? 2'b10 : 2'b01;
            expSeg = (expAn == 2'b10) ? 7'b1000000 : 7'b1111111;
            testsRun++;
            if (an !== expAn) begin
                testsFailed++;
                $display("[TB] FAIL refresh_an[%0d]: got %b, expected %b", i, an, expAn);
            end
            testsRun++;
            if (seg !== expSeg) begin
                testsFailed++;
                $display("[TB] FAIL refresh_seg[%0d]: got %b, expected %b", i, seg, expSeg);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_convert_30();
        int busyCnt, doneCnt, doneIdx, badAn, doneSeen;
        logic [6:0] doneSeg, onesSeg, tensSeg, expDone;
        logic [1:0] doneAn;
        logic [7:0] exp;
        applyStimulus(30);
        waitConversion(-1, 0, busyCnt, doneCnt, doneIdx, doneSeg, doneAn);
        if (sbQ.size() > 0) exp = sbQ.pop_front();
        else exp = 8'hFF;
        testsRun++;
        if (busyCnt != 7) begin testsFailed++; $display("[TB] FAIL c30_busy_cycles: got %0d, expected 7", busyCnt); end
        testsRun++;
        if (doneCnt != 1) begin testsFailed++; $display("[TB] FAIL c30_done_count: got %0d, expected 1", doneCnt); end
        testsRun++;
        if (doneIdx != 6) begin testsFailed++; $display("[TB] FAIL c30_done_cycle: got %0d, expected 6", doneIdx); end
        expDone = (doneAn == 2'b01) ? segCode(int'(exp[7:4]), 1'b1) : segCode(int'(exp[3:0]), 1'b0);
        testsRun++;
        if (doneSeg !== expDone) begin testsFailed++; $display("[TB] FAIL c30_seg_at_done: got %b, expected %b", doneSeg, expDone); end
        captureDisplay(onesSeg, tensSeg, badAn, doneSeen);
        testsRun++;
        if (onesSeg !== 7'b1000000) begin testsFailed++; $display("[TB] FAIL c30_ones: got %b, expected 1000000", onesSeg); end
        testsRun++;
        if (tensSeg !== 7'b0110000) begin testsFailed++; $display("[TB] FAIL c30_tens: got %b, expected 0110000", tensSeg); end
        testsRun++;
        if (badAn != 0) begin testsFailed++; $display("[TB] FAIL c30_an_legal: got %0d illegal samples, expected 0", badAn); end
    endtask

    task automatic test_blank();
        int busyCnt, doneCnt, doneIdx, badAn, doneSeen;
        logic [6:0] doneSeg, onesSeg, tensSeg;
        logic [1:0] doneAn;
        logic [7:0] exp;
        applyStimulus(9);
        waitConversion(-1, 0, busyCnt, doneCnt, doneIdx, doneSeg, doneAn);
        if (sbQ.size() > 0) exp = sbQ.pop_front();
        else exp = 8'hFF;
        captureDisplay(onesSeg, tensSeg, badAn, doneSeen);
        testsRun++;
        if (onesSeg !== segCode(int'(exp[3:0]), 1'b0)) begin testsFailed++; $display("[TB] FAIL blank_ones: got %b, expected 0010000", onesSeg); end
        testsRun++;
        if (tensSeg !== 7'b1111111) begin testsFailed++; $display("[TB] FAIL blank_tens: got %b, expected 1111111", tensSeg); end
    endtask

    task automatic test_back_to_back();
        int busyCnt, doneCnt, doneIdx, badAn, doneSeen, extra;
        logic [6:0] doneSeg, onesSeg, tensSeg;
        logic [1:0] doneAn;
        logic [7:0] exp;
        applyStimulus(17);
        waitConversion(2, 5, busyCnt, doneCnt, doneIdx, doneSeg, doneAn);
        if (sbQ.size() > 0) exp = sbQ.pop_front();
        else exp = 8'hFF;
        testsRun++;
        if (doneCnt != 1) begin testsFailed++; $display("[TB] FAIL b2b_done_count: got %0d, expected 1", doneCnt); end
        captureDisplay(onesSeg, tensSeg, badAn, doneSeen);
        extra = doneSeen;
        testsRun++;
        if (onesSeg !== segCode(int'(exp[3:0]), 1'b0)) begin testsFailed++; $display("[TB] FAIL b2b_ones: got %b, expected %b", onesSeg, segCode(int'(exp[3:0]), 1'b0)); end
        testsRun++;
        if (tensSeg !== segCode(int'(exp[7:4]), 1'b1)) begin testsFailed++; $display("[TB] FAIL b2b_tens: got %b, expected %b", tensSeg, segCode(int'(exp[7:4]), 1'b1)); end
        testsRun++;
        if (extra != 0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_no_second: got %0d extra done, busy %b, expected 0 and 0", extra, busy); end
    endtask

    task automatic test_reset_abort();
        int badAn, doneCap, doneSeen;
        logic [6:0] onesSeg, tensSeg;
        applyStimulus(22);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_busy: got %b, expected 0", busy); end
        if (sbQ.size() > 0) sbQ.delete(sbQ.size() - 1);
        doneSeen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        rst_n = 1'b1;
        captureDisplay(onesSeg, tensSeg, badAn, doneCap);
        testsRun++;
        if (doneSeen + doneCap != 0) begin testsFailed++; $display("[TB] FAIL abort_no_done: got %0d done pulses, expected 0", doneSeen + doneCap); end
        testsRun++;
        if (onesSeg !== 7'b1000000) begin testsFailed++; $display("[TB] FAIL abort_ones: got %b, expected 1000000", onesSeg); end
        testsRun++;
        if (tensSeg !== 7'b1111111) begin testsFailed++; $display("[TB] FAIL abort_tens: got %b, expected 1111111", tensSeg); end
    endtask

    task automatic test_first_load();
        int busyCnt, doneCnt, doneIdx, badAn, doneSeen;
        logic [6:0] doneSeg, onesSeg, tensSeg;
        logic [1:0] doneAn;
        logic [7:0] exp;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(12);
        waitConversion(-1, 0, busyCnt, doneCnt, doneIdx, doneSeg, doneAn);
        if (sbQ.size() > 0) exp = sbQ.pop_front();
        else exp = 8'hFF;
        testsRun++;
        if (busyCnt != 7) begin testsFailed++; $display("[TB] FAIL first_load_busy: got %0d, expected 7", busyCnt); end
        captureDisplay(onesSeg, tensSeg, badAn, doneSeen);
        testsRun++;
        if (onesSeg !== segCode(int'(exp[3:0]), 1'b0) || tensSeg !== segCode(int'(exp[7:4]), 1'b1)) begin
            testsFailed++;
            $display("[TB] FAIL first_load_digits: got tens %b ones %b, expected tens %b ones %b",
                     tensSeg, onesSeg, segCode(int'(exp[7:4]), 1'b1), segCode(int'(exp[3:0]), 1'b0));
        end
    endtask

    task automatic test_sweep();
        int busyCnt, doneCnt, doneIdx, badAn, doneSeen;
        logic [6:0] doneSeg, onesSeg, tensSeg;
        logic [1:0] doneAn;
        logic [7:0] exp;
        for (int v = 0; v <= 30; v++) begin
            applyStimulus(v);
            waitConversion(-1, 0, busyCnt, doneCnt, doneIdx, doneSeg, doneAn);
            if (sbQ.size() > 0) exp = sbQ.pop_front();
            else exp = 8'hFF;
            testsRun++;
            if (doneCnt != 1) begin testsFailed++; $display("[TB] FAIL sweep_done[%0d]: got %0d, expected 1", v, doneCnt); end
            captureDisplay(onesSeg, tensSeg, badAn, doneSeen);
            testsRun++;
            if (onesSeg !== segCode(int'(exp[3:0]), 1'b0)) begin
                testsFailed++;
                $display("[TB] FAIL sweep_ones[%0d]: got %b, expected %b", v, onesSeg, segCode(int'(exp[3:0]), 1'b0));
            end
            testsRun++;
            if (tensSeg !== segCode(int'(exp[7:4]), 1'b1)) begin
                testsFailed++;
                $display("[TB] FAIL sweep_tens[%0d]: got %b, expected %b", v, tensSeg, segCode(int'(exp[7:4]), 1'b1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_refresh();
        test_convert_30();
        test_blank();
        test_back_to_back();
        test_reset_abort();
        test_first_load();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sum_display_driver.md
SUM_DISPLAY_DRIVER -- requirements
Module: sum_display_driver

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 50000, meaning clock cycles per displayed digit (legal range >= 2).
REQ-002 SHALL provide parameter BLANK_LZ, default 1, meaning blank the tens digit when it is 0.
REQ-003 SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-004 in_clk  input  1  system clock; all state changes on rising edge.
REQ-005 in_rst_n  input  1  asynchronous active-low reset.
REQ-006 in_sum  input  5  unsigned result from the 4-bit adder stage (range 0..30; bit 4 = carry out).
REQ-007 in_load  input  1  single-cycle request to capture in_sum and convert it.
REQ-008 out_seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-009 out_an  output  2  digit anode select, active-low; bit 0 = ones digit, bit 1 = tens digit.
REQ-010 out_busy  output  1  high while a conversion is in progress.
REQ-011 out_done  output  1  one-cycle pulse when new digits are committed to the display.

Function
REQ-012 FSM states SHALL be IDLE, CONV and COMMIT.
REQ-013 In IDLE with in_load=1 at edge k: capture in_sum into a 5-bit shift register, clear BCD registers, go to CONV.
REQ-014 CONV SHALL run exactly 5 iterations, one per cycle (edges k+1..k+5).
REQ-015 Each CONV iteration: if ones >= 5, add 3 to ones; if tens >= 5, add 3 to tens; then shift {tens,ones,shift_reg} left by one bit.
REQ-016 After the 5th iteration the FSM SHALL go to COMMIT.
REQ-017 COMMIT at edge k+6 SHALL copy tens[3:0] and ones[3:0] into display registers, assert out_done for that one cycle, then return to IDLE.
REQ-018 Result timing: out_done is high in the cycle following edge k+6; new digits appear on out_seg no later than that cycle.
REQ-019 out_busy SHALL be high from edge k through edge k+6, i.e. in CONV and COMMIT.
REQ-020 in_load while out_busy=1 SHALL be ignored; there is no queueing.
REQ-021 in_sum changes during a conversion SHALL NOT affect the result.
REQ-022 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-023 The digit select SHALL toggle on each wrap, so each digit is shown for REFRESH_DIV cycles.
REQ-024 Refresh SHALL run continuously and independently of the FSM; a display-register update does not reset the counter.
REQ-025 out_an SHALL be 2'b10 when the ones digit is selected and 2'b01 when the tens digit is selected; never 2'b00.
REQ-026 Segment codes SHALL be:
- 0=1000000
- 1=1111001
- 2=0100100
- 3=0110000
- 4=0011001
- 5=0010010
- 6=0000010
- 7=1111000
- 8=0000000
- 9=0010000
REQ-027 Any other digit value SHALL drive 0111111 (dash).
REQ-028 With the tens digit selected, tens=0 and BLANK_LZ=1: out_seg SHALL be 1111111 while out_an still follows REQ-025.
REQ-029 out_seg and out_an SHALL be registered, so they change only on clock edges.

Reset
REQ-030 While in_rst_n=0: FSM=IDLE, out_busy=0, out_done=0, shift/BCD/display registers=0, refresh counter=0, digit select=ones, out_an=2'b10, out_seg=1000000.
REQ-031 Reset asserted mid-conversion SHALL abort it; no out_done SHALL be produced and the display SHALL show 0.
REQ-032 After reset deassertion the block SHALL accept in_load on the first rising edge.

Verification
REQ-033 With REFRESH_DIV=4: in_sum=30 with an in_load pulse -> out_busy high for 7 cycles, out_done pulse at k+6; display shows tens 0110000 and ones 1000000.
REQ-034 in_sum=9 converted, BLANK_LZ=1 -> ones 0010000; tens slot 1111111 with out_an=2'b01.
REQ-035 in_sum=17 loaded, then in_load with in_sum=5 at k+3 -> second load ignored; display shows 1 and 7; one out_done only.
REQ-036 REFRESH_DIV=4, idle after reset -> out_an sequence 10,10,10,10,01,01,01,01,10... for 8+ cycles.
REQ-037 Load in_sum=22, assert in_rst_n=0 at k+3 -> out_busy=0 immediately; no out_done; after release the display shows 0 and tens is blank.
REQ-038 Exhaustive sweep in_sum=0..30, each loaded and converted -> committed tens/ones equal in_sum/10 and in_sum%10.
